// File: rtl/pipeline_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles the hazard-detection inputs coming from the datapath and the
// stall/flush/bubble controls going back into the pipeline registers.
//
// Signals:
//   MemRead_EX, Write_register_EX  : load in EX and its destination register
//   rs_ID, rt_ID, uses_rt_ID       : source operands of the instruction in ID
//   branch_taken_EX                : branch/jump resolved taken in EX
//   mem_req_MEM, mem_ready         : data-memory access in MEM and completion
//   hold_PC, hold_IF_ID            : front-end hold enables
//   flush_IF_ID                    : IF_ID loads a NOP
//   bubble_ID_EX                   : ID_EX control fields zeroed
//   hold_EX_MEM                    : EX_MEM and ID_EX keep their values
//   bubble_MEM_WB                  : MEM_WB write-back controls zeroed
//   mem_timeout                    : sticky memory-wait timeout flag
//   busy                           : controller is not in its RUN state
//
// Modports:
//   master : datapath side (drives hazard inputs, receives controls)
//   slave  : hazard controller side
// ---------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if;
    logic       MemRead_EX;
    logic [4:0] Write_register_EX;
    logic [4:0] rs_ID;
    logic [4:0] rt_ID;
    logic       uses_rt_ID;
    logic       branch_taken_EX;
    logic       mem_req_MEM;
    logic       mem_ready;
    logic       hold_PC;
    logic       hold_IF_ID;
    logic       flush_IF_ID;
    logic       bubble_ID_EX;
    logic       hold_EX_MEM;
    logic       bubble_MEM_WB;
    logic       mem_timeout;
    logic       busy;

    modport master (
        output MemRead_EX, Write_register_EX, rs_ID, rt_ID, uses_rt_ID,
               branch_taken_EX, mem_req_MEM, mem_ready,
        input  hold_PC, hold_IF_ID, flush_IF_ID, bubble_ID_EX,
               hold_EX_MEM, bubble_MEM_WB, mem_timeout, busy
    );

    modport slave (
        input  MemRead_EX, Write_register_EX, rs_ID, rt_ID, uses_rt_ID,
               branch_taken_EX, mem_req_MEM, mem_ready,
        output hold_PC, hold_IF_ID, flush_IF_ID, bubble_ID_EX,
               hold_EX_MEM, bubble_MEM_WB, mem_timeout, busy
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall/flush controller for a 5-stage pipeline. Detects load-use
// hazards, squashes wrong-path instructions after a taken branch, and
// freezes the pipeline while a multi-cycle data-memory access is pending
// (with a forced release after MEM_TIMEOUT wait cycles).
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   hz     : pipeline_hazard_ctrl_if.slave (hazard inputs, stage controls)
//   stall_cycles, flush_count, loaduse_count : saturating statistics
//                                              (only with HAZARD_STATS_EN)
//
// Parameters:
//   MEM_TIMEOUT : max wait cycles before a memory access is discarded
//   CNT_W       : width of the wait counter and statistics counters
//
// Build option: define HAZARD_STATS_EN to add the statistics counters.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef HAZARD_STATS_EN
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic [CNT_W-1:0]      loaduse_count,
`endif
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_cnt_next;
    logic             timeout_q;
    logic             timeout_set;
    logic             load_use;
    logic             mem_stall;
    logic             hold_pc_c;
    logic             hold_if_id_c;
    logic             flush_if_id_c;
    logic             bubble_id_ex_c;
    logic             hold_ex_mem_c;
    logic             bubble_mem_wb_c;
    logic             flush_event;
    logic             loaduse_event;

    assign load_use = hz.MemRead_EX && (hz.Write_register_EX != 5'd0) &&
                      ((hz.Write_register_EX == hz.rs_ID) ||
                       (hz.uses_rt_ID && (hz.Write_register_EX == hz.rt_ID)));
    assign mem_stall = hz.mem_req_MEM && !hz.mem_ready;

    // Next-state and stall decisions. Memory stalls outrank branch flushes,
    // which outrank load-use stalls; EX-stage hazards are ignored while EX is
    // frozen (MEM_WAIT) or holds the squashed bubble (FLUSH).
    always_comb begin
        state_next      = state;
        wait_cnt_next   = wait_cnt;
        timeout_set     = 1'b0;
        hold_pc_c       = 1'b0;
        hold_if_id_c    = 1'b0;
        flush_if_id_c   = 1'b0;
        bubble_id_ex_c  = 1'b0;
        hold_ex_mem_c   = 1'b0;
        bubble_mem_wb_c = 1'b0;
        flush_event     = 1'b0;
        loaduse_event   = 1'b0;
        case (state)
            RUN: begin
                if (mem_stall) begin
                    hold_pc_c       = 1'b1;
                    hold_if_id_c    = 1'b1;
                    hold_ex_mem_c   = 1'b1;
                    bubble_mem_wb_c = 1'b1;
                    state_next      = MEM_WAIT;
                    wait_cnt_next   = CNT_W'(1);
                end else if (hz.branch_taken_EX) begin
                    flush_if_id_c  = 1'b1;
                    bubble_id_ex_c = 1'b1;
                    flush_event    = 1'b1;
                    state_next     = FLUSH;
                end else if (load_use) begin
                    hold_pc_c      = 1'b1;
                    hold_if_id_c   = 1'b1;
                    bubble_id_ex_c = 1'b1;
                    loaduse_event  = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_next    = RUN;
                    wait_cnt_next = '0;
                end else if (wait_cnt == TIMEOUT_VAL) begin
                    // Give up on the access: release the pipeline but keep
                    // the stale MEM result from being written back.
                    timeout_set     = 1'b1;
                    bubble_mem_wb_c = 1'b1;
                    state_next      = RUN;
                    wait_cnt_next   = '0;
                end else begin
                    hold_pc_c       = 1'b1;
                    hold_if_id_c    = 1'b1;
                    hold_ex_mem_c   = 1'b1;
                    bubble_mem_wb_c = 1'b1;
                    if (wait_cnt != CNT_MAX) begin
                        wait_cnt_next = wait_cnt + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (mem_stall) begin
                    hold_pc_c       = 1'b1;
                    hold_if_id_c    = 1'b1;
                    hold_ex_mem_c   = 1'b1;
                    bubble_mem_wb_c = 1'b1;
                    state_next      = MEM_WAIT;
                    wait_cnt_next   = CNT_W'(1);
                end else begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next    = RUN;
                wait_cnt_next = '0;
            end
        endcase
    end

    // Controls are gated with rst_n so that no stage is held or bubbled
    // while reset is asserted, even if the hazard inputs are active.
    assign hz.hold_PC       = hold_pc_c       & rst_n;
    assign hz.hold_IF_ID    = hold_if_id_c    & rst_n;
    assign hz.flush_IF_ID   = flush_if_id_c   & rst_n;
    assign hz.bubble_ID_EX  = bubble_id_ex_c  & rst_n;
    assign hz.hold_EX_MEM   = hold_ex_mem_c   & rst_n;
    assign hz.bubble_MEM_WB = bubble_mem_wb_c & rst_n;
    assign hz.mem_timeout   = timeout_q;
    assign hz.busy          = (state != RUN);

    // State, wait counter and the sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
            if (timeout_set) begin
                timeout_q <= 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    // Saturating event counters for performance analysis.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles  <= '0;
            flush_count   <= '0;
            loaduse_count <= '0;
        end else begin
            if (hold_ex_mem_c && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_event && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + CNT_W'(1);
            end
            if (loaduse_event && (loaduse_count != CNT_MAX)) begin
                loaduse_count <= loaduse_count + CNT_W'(1);
            end
        end
    end
`endif

endmodule
